ym3438_io_buf: RTL and testbench

YM3438_IO_BUF -- requirements
Module: ym3438_io_buf

---
 rtl/ym3438_pkg.sv | 24 ++
 rtl/ym3438_io_buf_if.sv | 13 +
 rtl/ym3438_fifo.sv | 50 +++++
 rtl/ym3438_io_buf.sv | 127 ++++++++++++
 tb/tb_ym3438_io_buf.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ym3438_pkg.sv
// Shared types and constants for the YM3438 host I/O buffer.
package ym3438_pkg;

   localparam int BANK_W_MAX = 4;

   localparam int STAT_BUSY = 7;
   localparam int STAT_OVF  = 6;
   localparam int STAT_TB   = 1;
   localparam int STAT_TA   = 0;

   typedef struct packed {
      logic [BANK_W_MAX-1:0] bank;
      logic [7:0]            addr;
      logic [7:0]            data;
   } fifo_entry_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/ym3438_io_buf_if.sv
// Register-write handshake between the host buffer and the chip register file.
interface ym3438_io_buf_if #(
   parameter int BANK_W = 1
) ();
   logic              wr_valid;
   logic              wr_ready;
   logic [BANK_W-1:0] wr_bank;
   logic [7:0]        wr_addr;
   logic [7:0]        wr_data;

   modport master (output wr_valid, wr_bank, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_bank, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ym3438_fifo.sv
// Power-of-two write queue with occupancy level; accepts a push at full when a pop frees a slot.
module ym3438_fifo import ym3438_pkg::*; #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int PTR_W = clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             push_ok,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_ok;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ym3438_io_buf.sv
// Host-side buffer for the YM3438 register port: address latch, write queue,
// busy timer, status readback and timer interrupt.
module ym3438_io_buf import ym3438_pkg::*; #(
   parameter int  FIFO_DEPTH  = 4,
   parameter int  BUSY_CYCLES = 32,
   parameter int  BANK_W      = 1,
   localparam int LVL_W       = clog2(FIFO_DEPTH) + 1
) (
   input  logic             MCLK,
   input  logic             IC,
   input  logic             clk_en,
   input  logic             CS,
   input  logic             WR,
   input  logic             RD,
   input  logic [BANK_W:0]  address,
   input  logic [7:0]       data_i,
   input  logic             timer_a,
   input  logic             timer_b,
   input  logic [1:0]       irq_mask,
   input  logic             dbg_sel,
   input  logic [7:0]       dbg_data,
   ym3438_io_buf_if.master  wr_if,
   output logic [7:0]       data_o,
   output logic             data_oe,
   output logic             busy,
   output logic             irq,
   output logic             overflow,
   output logic [LVL_W-1:0] fifo_level
);
   localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES);

   logic [1:0]        rst_sync;
   logic              rst_n;
   logic              wr_act, wr_act_q, rd_act_q;
   logic              host_wr, push_req, push_ok, pop, rd_end;
   logic              fifo_full, fifo_empty;
   logic [BANK_W-1:0] bank_q;
   logic [7:0]        addr_q;
   logic [7:0]        busy_cnt;
   logic [7:0]        status;
   fifo_entry_t       push_entry, head;

   // IC clears everything at once; release passes two flops so it lands on an MCLK edge
   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) rst_sync <= '0;
      else     rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign wr_act   = ~CS & ~WR;
   assign host_wr  = wr_act & ~wr_act_q;
   assign push_req = host_wr & address[0];
   assign pop      = ~fifo_empty & wr_if.wr_ready & clk_en;
   assign rd_end   = ~CS & RD & rd_act_q & ~dbg_sel;

   always_comb begin
      push_entry      = '0;
      push_entry.bank = BANK_W_MAX'(bank_q);
      push_entry.addr = addr_q;
      push_entry.data = data_i;
   end

   ym3438_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (MCLK),
      .rst_n   (rst_n),
      .push    (push_req),
      .pop     (pop),
      .din     (push_entry),
      .dout    (head),
      .push_ok (push_ok),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign wr_if.wr_valid = ~fifo_empty;
   assign wr_if.wr_bank  = head.bank[BANK_W-1:0];
   assign wr_if.wr_addr  = head.addr;
   assign wr_if.wr_data  = head.data;

   if (BANK_W < BANK_W_MAX) begin : g_bank_pad
      logic unused_bank;
      assign unused_bank = ^head.bank[BANK_W_MAX-1:BANK_W];
   end

   assign busy    = (busy_cnt != 8'd0) | ~fifo_empty;
   assign data_oe = rst_n & ~CS & ~RD;

   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy;
      status[STAT_OVF]  = overflow;
      status[STAT_TB]   = timer_b;
      status[STAT_TA]   = timer_a;
   end

   always_ff @(posedge MCLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_act_q <= 1'b0;
         rd_act_q <= 1'b0;
         bank_q   <= '0;
         addr_q   <= '0;
         busy_cnt <= '0;
         overflow <= 1'b0;
         data_o   <= '0;
         irq      <= 1'b0;
      end else begin
         wr_act_q <= wr_act;
         rd_act_q <= ~CS & ~RD;
         if (host_wr & ~address[0]) begin
            bank_q <= address[BANK_W:1];
            addr_q <= data_i;
         end
         if (push_ok)                          busy_cnt <= BUSY_LOAD;
         else if (clk_en && busy_cnt != 8'd0)  busy_cnt <= busy_cnt - 8'd1;
         // a dropped push in the same cycle as the read end keeps the flag set
         if (push_req & ~push_ok) overflow <= 1'b1;
         else if (rd_end)         overflow <= 1'b0;
         data_o <= data_oe ? (dbg_sel ? dbg_data : status) : 8'h00;
         irq    <= (timer_a & ~irq_mask[0]) | (timer_b & ~irq_mask[1]);
      end
   end

endmodule

// File: tb/tb_ym3438_io_buf.sv
// Directed bench for ym3438_io_buf: vector table for readback/IRQ plus queue sequences.
module tb_ym3438_io_buf;

   logic       MCLK = 1'b0;
   logic       IC = 1'b0;
   logic       clk_en = 1'b0;
   logic       CS = 1'b1;
   logic       WR = 1'b1;
   logic       RD = 1'b1;
   logic [1:0] address = '0;
   logic [7:0] data_i = '0;
   logic       timer_a = 1'b0;
   logic       timer_b = 1'b0;
   logic [1:0] irq_mask = '0;
   logic       dbg_sel = 1'b0;
   logic [7:0] dbg_data = '0;
   logic [7:0] data_o;
   logic       data_oe, busy, irq, overflow;
   logic [2:0] fifo_level;

   ym3438_io_buf_if #(.BANK_W(1)) wr_if ();

   ym3438_io_buf #(.FIFO_DEPTH(4), .BUSY_CYCLES(32), .BANK_W(1)) dut (
      .MCLK       (MCLK),
      .IC         (IC),
      .clk_en     (clk_en),
      .CS         (CS),
      .WR         (WR),
      .RD         (RD),
      .address    (address),
      .data_i     (data_i),
      .timer_a    (timer_a),
      .timer_b    (timer_b),
      .irq_mask   (irq_mask),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data),
      .wr_if      (wr_if),
      .data_o     (data_o),
      .data_oe    (data_oe),
      .busy       (busy),
      .irq        (irq),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 MCLK = ~MCLK;

   int checks = 0;
   int errors = 0;
   int pop_count = 0;
   logic       pop_bank;
   logic [7:0] pop_addr, pop_data;

   // inputs change just after posedge, so the handshake seen here is the one the next edge takes
   always @(negedge MCLK) begin
      if (wr_if.wr_valid && wr_if.wr_ready && clk_en) begin
         pop_count++;
         pop_bank = wr_if.wr_bank;
         pop_addr = wr_if.wr_addr;
         pop_data = wr_if.wr_data;
      end
   end

   typedef struct {
      logic       cs, rd, wr, dbg;
      logic [7:0] dbg_d;
      logic       ta, tb;
      logic [1:0] mask;
      logic       exp_oe, exp_irq;
      logic [7:0] exp_do;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      IC = 1'b0;
      CS = 1'b1; WR = 1'b1; RD = 1'b1;
      clk_en = 1'b0;
      wr_if.wr_ready = 1'b0;
      repeat (3) tick();
      IC = 1'b1;
      repeat (4) tick();
   endtask

   task automatic host_write(input logic [1:0] a, input logic [7:0] d);
      address = a;
      data_i  = d;
      CS = 1'b0; WR = 1'b0;
      tick();
      CS = 1'b1; WR = 1'b1;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int base;
      logic [7:0] drain_exp [4];

      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h01};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 8'h01};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h02};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h02};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h03};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'hA5};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00};
      vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'h02};

      // reset state, with a read strobe held during reset
      wr_if.wr_ready = 1'b0;
      CS = 1'b0; RD = 1'b0;
      tick();
      chk("oe_in_reset", data_oe, 1'b0);
      do_reset();
      chk("rst_valid", wr_if.wr_valid, 1'b0);
      chk("rst_level", fifo_level, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_data_o", data_o, 8'h00);
      chk("rst_oe", data_oe, 1'b0);

      // readback / irq vector table
      foreach (vecs[i]) begin
         CS = vecs[i].cs; RD = vecs[i].rd; WR = vecs[i].wr;
         dbg_sel = vecs[i].dbg; dbg_data = vecs[i].dbg_d;
         timer_a = vecs[i].ta; timer_b = vecs[i].tb; irq_mask = vecs[i].mask;
         address = 2'b00; data_i = 8'h00;
         #1;
         chk($sformatf("vec%0d_oe", i), data_oe, vecs[i].exp_oe);
         tick();
         chk($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
         chk($sformatf("vec%0d_data_o", i), data_o, vecs[i].exp_do);
      end
      chk("vec_no_push", fifo_level, 3'd0);
      CS = 1'b1; WR = 1'b1; RD = 1'b1; dbg_sel = 1'b0;
      timer_a = 1'b0; timer_b = 1'b0; irq_mask = 2'b00;
      tick();

      // irq latency and masking
      timer_a = 1'b1; irq_mask = 2'b01;
      tick(); tick();
      chk("irq_masked", irq, 1'b0);
      irq_mask = 2'b00;
      #1;
      chk("irq_latency", irq, 1'b0);
      tick();
      chk("irq_unmasked", irq, 1'b1);
      timer_a = 1'b0;
      tick();

      // single register write and busy hold
      do_reset();
      wr_if.wr_ready = 1'b1;
      base = pop_count;
      host_write(2'b00, 8'h28);
      chk("addr_only_level", fifo_level, 3'd0);
      host_write(2'b01, 8'hF0);
      chk("w1_valid", wr_if.wr_valid, 1'b1);
      chk("w1_bank", wr_if.wr_bank, 1'b0);
      chk("w1_addr", wr_if.wr_addr, 8'h28);
      chk("w1_data", wr_if.wr_data, 8'hF0);
      chk("w1_busy", busy, 1'b1);
      pulses = 0;
      while (busy && pulses < 100) begin
         clk_en = 1'b1;
         tick();
         clk_en = 1'b0;
         tick(); tick();
         pulses++;
      end
      chk("busy_ticks", pulses, 32);
      chk("w1_pops", pop_count - base, 1);
      chk("w1_pop_bank", pop_bank, 1'b0);
      chk("w1_pop_addr", pop_addr, 8'h28);
      chk("w1_pop_data", pop_data, 8'hF0);
      chk("w1_empty", wr_if.wr_valid, 1'b0);

      // overflow: five data writes into a depth-4 queue with no drain
      do_reset();
      wr_if.wr_ready = 1'b0;
      host_write(2'b00, 8'h20);
      for (int k = 0; k < 5; k++) host_write(2'b01, 8'h31 + 8'(k));
      chk("ovf_level", fifo_level, 3'd4);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_head", wr_if.wr_data, 8'h31);
      chk("ovf_busy", busy, 1'b1);

      // status read then read end clears overflow
      CS = 1'b0; RD = 1'b0;
      #1;
      chk("st_oe", data_oe, 1'b1);
      tick();
      chk("st_data_o", data_o, 8'hC0);
      chk("st_ovf_held", overflow, 1'b1);
      RD = 1'b1;
      tick();
      chk("st_ovf_clr", overflow, 1'b0);
      CS = 1'b1;
      tick();

      // push and pop in the same cycle while full
      base = pop_count;
      address = 2'b01; data_i = 8'h36;
      CS = 1'b0; WR = 1'b0;
      wr_if.wr_ready = 1'b1; clk_en = 1'b1;
      tick();
      CS = 1'b1; WR = 1'b1;
      wr_if.wr_ready = 1'b0; clk_en = 1'b0;
      chk("pp_level", fifo_level, 3'd4);
      chk("pp_ovf", overflow, 1'b0);
      chk("pp_pops", pop_count - base, 1);
      chk("pp_pop_data", pop_data, 8'h31);
      tick();

      drain_exp[0] = 8'h32; drain_exp[1] = 8'h33;
      drain_exp[2] = 8'h34; drain_exp[3] = 8'h36;
      wr_if.wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_valid", k), wr_if.wr_valid, 1'b1);
         chk($sformatf("drain%0d_data", k), wr_if.wr_data, drain_exp[k]);
         chk($sformatf("drain%0d_addr", k), wr_if.wr_addr, 8'h20);
         clk_en = 1'b1;
         tick();
         clk_en = 1'b0;
      end
      chk("drain_empty", wr_if.wr_valid, 1'b0);
      chk("drain_level", fifo_level, 3'd0);
      wr_if.wr_ready = 1'b0;

      // IC pulse with three entries queued
      do_reset();
      host_write(2'b10, 8'h40);
      host_write(2'b01, 8'hA1);
      host_write(2'b01, 8'hA2);
      host_write(2'b01, 8'hA3);
      chk("ic_pre_level", fifo_level, 3'd3);
      chk("ic_pre_bank", wr_if.wr_bank, 1'b1);
      chk("ic_pre_addr", wr_if.wr_addr, 8'h40);
      base = pop_count;
      IC = 1'b0;
      wr_if.wr_ready = 1'b1; clk_en = 1'b1;
      #1;
      chk("ic_valid", wr_if.wr_valid, 1'b0);
      chk("ic_level", fifo_level, 3'd0);
      chk("ic_busy", busy, 1'b0);
      tick(); tick();
      IC = 1'b1;
      repeat (4) tick();
      chk("ic_no_pop", pop_count - base, 0);
      chk("ic_post_valid", wr_if.wr_valid, 1'b0);
      chk("ic_post_level", fifo_level, 3'd0);
      clk_en = 1'b0; wr_if.wr_ready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
